bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 85 ++++++++
 tb/tb_bin2bcd_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit packed BCD converter (double-dabble).
// One bit is shifted per clock; the result is held in DONE until taken downstream.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_bcd,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and the producer holds data until then.

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] work;
  logic [19:0] work_adj;
  logic [19:0] work_shift;
  logic [3:0]  cnt;

  // BCD digits live in [19:8]; a digit >=5 gets +3 so the shift carries into the next decimal place.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 3; i++) begin
      if (work[8 + 4*i +: 4] >= 4'd5) begin
        work_adj[8 + 4*i +: 4] = work[8 + 4*i +: 4] + 4'd3;
      end
    end
    work_shift = work_adj << 1;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 4'd7) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= 20'h0_0000;
      cnt     <= 4'd0;
      out_bcd <= 12'h000;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= {12'h000, in_bin};
            cnt  <= 4'd0;
          end
        end
        SHIFT: begin
          work <= work_shift;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd7) out_bcd <= work_shift[19:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed corner values, stall/hold, input noise
// during conversion, exhaustive sweep with random stalls and mid-conversion reset.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  bin2bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: decimal digits by plain arithmetic
  function automatic logic [11:0] golden(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // driver: one full conversion; noisy=1 toggles in_valid/in_bin while busy
  task automatic convert(input logic [7:0] v, input int stall, input bit noisy);
    int n;
    int busy_cnt;
    logic [11:0] exp;
    logic [11:0] held;
    check("idle_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_bin   = v;
    exp_q.push_back(golden(int'(v)));
    tick();
    in_valid = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!out_valid && n < 20) begin
      if (busy) busy_cnt++;
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_bin   = 8'($urandom);
      end
      tick();
      n++;
    end
    check("latency", n, 8);
    check("busy_cycles", busy_cnt, 8);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
    check("out_bcd", out_bcd, exp);
    check("done_in_ready", in_ready, 1'b0);
    held = out_bcd;
    for (int i = 0; i < stall; i++) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_bin   = 8'($urandom);
      end
      tick();
      check("stall_valid", out_valid, 1'b1);
      check("stall_bcd", out_bcd, held);
      check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_idle", in_ready, 1'b1);
    check("release_hold_bcd", out_bcd, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = 8'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_bcd", out_bcd, 12'h000);
    rst_n = 1'b1;

    // directed corner values
    convert(8'd0,   0, 1'b0);
    convert(8'd255, 0, 1'b0);
    convert(8'd99,  0, 1'b0);
    convert(8'd100, 0, 1'b0);
    convert(8'd9,   0, 1'b0);
    convert(8'd173, 20, 1'b0);

    // input noise while converting
    convert(8'd58, 2, 1'b1);

    // exhaustive sweep with random downstream stalls
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      check("digit_range", {19'd0, (out_bcd[11:8] <= 4'd2) && (out_bcd[7:4] <= 4'd9) && (out_bcd[3:0] <= 4'd9)}, 20'd1);
    end

    // random values
    for (int k = 0; k < 20; k++) begin
      convert(8'($urandom), int'($urandom_range(0, 5)), 1'b1);
    end

    // reset in the middle of converting 200
    in_valid = 1'b1;
    in_bin   = 8'd200;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_bcd", out_bcd, 12'h000);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
    end
    convert(8'd42, 1, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
